microwave_cook_timer: RTL
=========================

# microwave_cook_timer

Cook-time sequencer for the microwave oven controller. Holds the user-programmed cook time and counts it down in whole seconds, but only while the door FSM reports active cooking on `run` (its `heat` output). It duty-cycles the magnetron according to a power level and issues the one-cycle `finish` pulse that moves the door FSM from cooking to bell.

## Interface
Parameters:
- `TICKS_PER_SEC`, 1000: clock cycles per second; must be ≥ 2.
- `TIME_W`, 8: width of the cook-time counter, in seconds.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `nrst`  in  1  reset; asynchronous, active-low.
- `load`  in  1  single-cycle strobe that captures `time_in` and `power`.
- `time_in`  in  TIME_W  cook time in seconds.
- `power`  in  2  power level; 0/1/2/3 = 25/50/75/100 %.
- `run`  in  1  high while the door FSM is cooking; connect to its `heat`.
- `clear`  in  1  synchronous abort.
- `finish`  out  1  one-cycle pulse when the countdown reaches 0.
- `mag_on`  out  1  magnetron enable.
- `remaining`  out  TIME_W  seconds left.
- `busy`  out  1  high when a cook time is loaded or counting.

## Operation
- States:
  - IDLE: no time loaded.
  - ARMED: time loaded, not counting. Covers both "loaded, never started" and "paused".
  - RUN: counting.
  - DONE: single cycle.
- Internal registers:
  - Prescaler `pre`, 0..TICKS_PER_SEC-1.
  - 2-bit power phase `ph`, seconds within the 4-second power period.
  - Latched power `pwr`.
- Priority: `nrst`, then `clear`, then everything else.
- `clear`: next state IDLE, `remaining`=0, `pre`=0, `ph`=0. No `finish` is issued, even if a decrement was due that cycle.
- `load`:
  - Accepted only in IDLE or ARMED, and only when `time_in` ≠ 0.
  - Effect: `remaining`←`time_in`, `pwr`←`power`, `pre`←0, `ph`←0, next state ARMED.
  - `load` in RUN or DONE is ignored. `load` with `time_in`=0 is ignored in every state.
- ARMED with `run`=1: next state RUN. `pre` is not incremented in that cycle.
- RUN with `run`=1:
  - `pre` increments each cycle.
  - When `pre`=TICKS_PER_SEC-1: `pre`←0, `remaining` decrements, `ph` increments (wraps 3→0).
  - If `remaining`=1 at that moment, next state is DONE.
- RUN with `run`=0: next state ARMED. `pre`, `ph` and `remaining` hold, so a partial second resumes where it stopped.
- DONE: `finish`=1 for exactly this cycle, then IDLE unconditionally. `remaining` is 0.
- IDLE ignores `run`.
- Outputs:
  - `finish` = (state==DONE).
  - `busy` = (state ∈ {ARMED, RUN}).
  - `mag_on` = (state==RUN) & `run` & (`ph` ≤ `pwr`). It is the only output that depends combinationally on an input; all others are decoded from registers only.
- Power 3 gives continuous `mag_on` while RUN. Power 0 gives `mag_on` in the first second of every 4.

## Timing
- Reset values: state IDLE, `remaining`=0, `pre`=0, `ph`=0, `pwr`=0. Outputs `finish`=0, `mag_on`=0, `busy`=0.
- `load` sampled at edge k: `remaining` and `busy` are valid after edge k.
- ARMED→RUN: first edge with `run`=1.
- Counting: each second needs TICKS_PER_SEC RUN cycles with `run`=1, counted from `pre`=0. A fresh T-second cook therefore needs T·TICKS_PER_SEC such cycles.
- The final decrement edge enters DONE. `finish` is high in the following cycle only. The door FSM samples it at the next edge, while still cooking.
- `run` falling in the same cycle `pre` would wrap: no increment and no decrement. The wrap happens after resume.
- Reset mid-operation returns every register to its reset value immediately; no `finish` is issued.

## Test plan
- **Basic cook** (TICKS_PER_SEC=4): `load` `time_in`=3, `power`=3, then hold `run`=1.
  - `remaining` steps 3→2→1→0, one step per 4 RUN cycles.
  - `finish` is a single pulse in the cycle after the 12th counting cycle.
  - `mag_on` is continuously 1 in RUN.
  - `busy` drops with DONE.
- **Pause/resume**: as above, drop `run` after 6 counting cycles.
  - Holds `remaining`=2 and `pre`=2 through 10 ARMED cycles.
  - After `run`=1 returns: one ARMED→RUN cycle, then 2 counting cycles reach `remaining`=1.
- **Power duty**: `time_in`=8, `power`=1. `mag_on` is high for seconds 0–1 and 4–5, low for seconds 2–3 and 6–7.
- **Ignored loads**:
  - `load` during RUN with `time_in`=9: `remaining` unaffected.
  - `load` with `time_in`=0 in IDLE: stays IDLE, `busy`=0.
  - `load` `time_in`=5 in ARMED: reloads 5 and `pre`=0.
- **Abort**: `clear` on the cycle `remaining` would go 1→0. Result is IDLE, `remaining`=0, and `finish` never asserts.
- **Reset mid-run**: assert `nrst`=0 asynchronously while RUN with `remaining`=4. All outputs read 0 before the next clock edge; after release the block stays IDLE with `run`=1.

Source files
------------

// File: rtl/microwave_cook_timer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | microwave_cook_timer: whole-second cook countdown with duty-cycled     |
// | magnetron enable and one-cycle finish pulse.                 rev 1.0   |
// +------------------------------------------------------------------------+
module microwave_cook_timer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TIME_W        = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [1:0]        power,
  input  logic              run,
  input  logic              clear,
  output logic              finish,
  output logic              mag_on,
  output logic [TIME_W-1:0] remaining,
  output logic              busy
);

  localparam int c_PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICKS_PER_SEC - 1);
  localparam logic [TIME_W-1:0]  c_ONE_SEC = TIME_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TIME_W-1:0]   r_remaining;
  logic [TIME_W-1:0]   w_remaining_nxt;
  logic [c_PRE_W-1:0]  r_pre;
  logic [c_PRE_W-1:0]  w_pre_nxt;
  logic [1:0]          r_ph;
  logic [1:0]          w_ph_nxt;
  logic [1:0]          r_pwr;
  logic [1:0]          w_pwr_nxt;
  logic                w_load_ok;
  logic                w_wrap;

  assign w_load_ok = load && (time_in != '0);
  assign w_wrap    = (r_pre == c_PRE_MAX);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_pre       <= '0;
      r_ph        <= '0;
      r_pwr       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_pre       <= w_pre_nxt;
      r_ph        <= w_ph_nxt;
      r_pwr       <= w_pwr_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_pre_nxt       = r_pre;
    w_ph_nxt        = r_ph;
    w_pwr_nxt       = r_pwr;

    if (clear) begin
      // Abort wins over a due decrement, so DONE is never reached from here.
      w_state_nxt     = S_IDLE;
      w_remaining_nxt = '0;
      w_pre_nxt       = '0;
      w_ph_nxt        = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_load_ok) begin
            w_state_nxt     = S_ARMED;
            w_remaining_nxt = time_in;
            w_pwr_nxt       = power;
            w_pre_nxt       = '0;
            w_ph_nxt        = '0;
          end
        end
        S_ARMED: begin
          // A reload takes precedence over starting the count.
          if (w_load_ok) begin
            w_remaining_nxt = time_in;
            w_pwr_nxt       = power;
            w_pre_nxt       = '0;
            w_ph_nxt        = '0;
          end else if (run) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (!run) begin
            w_state_nxt = S_ARMED;
          end else if (w_wrap) begin
            w_pre_nxt       = '0;
            w_remaining_nxt = r_remaining - c_ONE_SEC;
            w_ph_nxt        = r_ph + 2'd1;
            if (r_remaining == c_ONE_SEC) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_pre_nxt = r_pre + c_PRE_W'(1);
          end
        end
        S_DONE: begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign finish    = (r_state == S_DONE);
  assign busy      = (r_state == S_ARMED) || (r_state == S_RUN);
  assign remaining = r_remaining;
  assign mag_on    = (r_state == S_RUN) && run && (r_ph <= r_pwr);

endmodule
`default_nettype wire
